// File: rtl/coin_lane_array.sv
`default_nettype none
// ============================================================================
//  Module      : coin_lane_array
//  Description : Per-lane falling-coin spawner/renderer with collect/miss
//                detection and a saturating score counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module coin_lane_array #(
  parameter int N_LANES      = 3,
  parameter int LANE_X0      = 80,
  parameter int LANE_W       = 160,
  parameter int COIN_SIZE    = 32,
  parameter int Y_HIT        = 400,
  parameter int Y_END        = 480,
  parameter int STEP         = 4,
  parameter int FLASH_FRAMES = 8,
  parameter int SCORE_W      = 16,
  localparam int LW          = $clog2(N_LANES)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [15:0]        i_x,
  input  logic [15:0]        i_y,
  input  logic               i_v_sync,
  input  logic               i_pause,
  input  logic               i_spawn_valid,
  input  logic [LW-1:0]      i_spawn_lane,
  output logic               o_spawn_ready,
  input  logic [LW-1:0]      i_player_lane,
  output logic [7:0]         o_red,
  output logic [7:0]         o_green,
  output logic [7:0]         o_blue,
  output logic               o_sprite_hit,
  output logic [N_LANES-1:0] o_in_position,
  output logic               o_collect,
  output logic [LW-1:0]      o_collect_lane,
  output logic               o_miss,
  output logic [SCORE_W-1:0] o_score
);

  // Flash counter needs bit 1 for the blink decode, so never narrower than 2.
  localparam int FW = ($clog2(FLASH_FRAMES) < 2) ? 2 : $clog2(FLASH_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FALL  = 2'd1,
    S_FLASH = 2'd2
  } lane_state_e;

  lane_state_e       state_q [N_LANES];
  lane_state_e       state_d [N_LANES];
  logic [15:0]       y_q     [N_LANES];
  logic [15:0]       y_d     [N_LANES];
  logic [FW-1:0]     flash_q [N_LANES];
  logic [FW-1:0]     flash_d [N_LANES];

  logic              vs_q;
  logic              tick;
  logic              adv;
  logic              collect_q, collect_d;
  logic [LW-1:0]     collect_lane_q, collect_lane_d;
  logic              miss_q, miss_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [7:0]        red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic              hit_q, hit_d;
  logic [16:0]       y_next;
  logic              vis;
  logic              in_box;
  logic [16:0]       box_x0;

  assign tick = i_v_sync & ~vs_q;
  assign adv  = tick & ~i_pause;

  // Collectable flag per lane decoded straight from registered state.
  for (genvar k = 0; k < N_LANES; k++) begin : g_pos
    assign o_in_position[k] = (state_q[k] == S_FALL) && (y_q[k] >= 16'(Y_HIT));
  end

  // Spawn ready: lane index must exist and that lane must be idle.
  always_comb begin
    o_spawn_ready = 1'b0;
    for (int k = 0; k < N_LANES; k++) begin
      if (i_spawn_lane == LW'(k) && state_q[k] == S_IDLE) o_spawn_ready = 1'b1;
    end
  end

  // Per-lane next state: frame motion, collect, miss, flash countdown, spawn.
  always_comb begin
    collect_d      = 1'b0;
    collect_lane_d = collect_lane_q;
    miss_d         = 1'b0;
    score_d        = score_q;
    y_next         = 17'd0;
    for (int k = 0; k < N_LANES; k++) begin
      state_d[k] = state_q[k];
      y_d[k]     = y_q[k];
      flash_d[k] = flash_q[k];
      case (state_q[k])
        S_FALL: begin
          if (adv) begin
            if (o_in_position[k] && i_player_lane == LW'(k)) begin
              state_d[k]     = S_FLASH;
              flash_d[k]     = FW'(FLASH_FRAMES - 1);
              collect_d      = 1'b1;
              collect_lane_d = LW'(k);
              if (score_q != {SCORE_W{1'b1}}) score_d = score_q + SCORE_W'(1);
            end else begin
              y_next = {1'b0, y_q[k]} + 17'(STEP);
              y_d[k] = y_next[15:0];
              if (y_next >= 17'(Y_END)) begin
                state_d[k] = S_IDLE;
                miss_d     = 1'b1;
              end
            end
          end
        end
        S_FLASH: begin
          if (adv) begin
            if (flash_q[k] == '0) state_d[k] = S_IDLE;
            else                  flash_d[k] = flash_q[k] - FW'(1);
          end
        end
        default: begin
          // Idle lanes only change through a spawn; a tick has no effect.
          if (i_spawn_valid && i_spawn_lane == LW'(k)) begin
            state_d[k] = S_FALL;
            y_d[k]     = 16'd0;
          end
        end
      endcase
    end
  end

  // Pixel decode; loop runs high-to-low so the lowest lane index wins overlaps.
  always_comb begin
    red_d   = 8'h00;
    green_d = 8'h00;
    blue_d  = 8'h00;
    hit_d   = 1'b0;
    vis     = 1'b0;
    in_box  = 1'b0;
    box_x0  = 17'd0;
    for (int k = N_LANES - 1; k >= 0; k--) begin
      box_x0 = 17'(LANE_X0 + k * LANE_W + (LANE_W - COIN_SIZE) / 2);
      vis    = (state_q[k] == S_FALL) || (state_q[k] == S_FLASH && flash_q[k][1]);
      in_box = ({1'b0, i_x} >= box_x0) &&
               ({1'b0, i_x} <  box_x0 + 17'(COIN_SIZE)) &&
               ({1'b0, i_y} >= {1'b0, y_q[k]}) &&
               ({1'b0, i_y} <  {1'b0, y_q[k]} + 17'(COIN_SIZE));
      if (vis && in_box) begin
        hit_d = 1'b1;
        if (state_q[k] == S_FALL) begin
          red_d = 8'hFF; green_d = 8'hD7; blue_d = 8'h00;
        end else begin
          red_d = 8'hFF; green_d = 8'hFF; blue_d = 8'hFF;
        end
      end
    end
  end

  // State, pulse, score and pixel registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < N_LANES; k++) begin
        state_q[k] <= S_IDLE;
        y_q[k]     <= 16'd0;
        flash_q[k] <= '0;
      end
      vs_q           <= 1'b0;
      collect_q      <= 1'b0;
      collect_lane_q <= '0;
      miss_q         <= 1'b0;
      score_q        <= '0;
      red_q          <= 8'h00;
      green_q        <= 8'h00;
      blue_q         <= 8'h00;
      hit_q          <= 1'b0;
    end else begin
      for (int k = 0; k < N_LANES; k++) begin
        state_q[k] <= state_d[k];
        y_q[k]     <= y_d[k];
        flash_q[k] <= flash_d[k];
      end
      vs_q           <= i_v_sync;
      collect_q      <= collect_d;
      collect_lane_q <= collect_lane_d;
      miss_q         <= miss_d;
      score_q        <= score_d;
      red_q          <= red_d;
      green_q        <= green_d;
      blue_q         <= blue_d;
      hit_q          <= hit_d;
    end
  end

  assign o_collect      = collect_q;
  assign o_collect_lane = collect_lane_q;
  assign o_miss         = miss_q;
  assign o_score        = score_q;
  assign o_red          = red_q;
  assign o_green        = green_q;
  assign o_blue         = blue_q;
  assign o_sprite_hit   = hit_q;

endmodule
`default_nettype wire

// File: tb/tb_coin_lane_array.sv
`default_nettype none
// ============================================================================
//  Module      : tb_coin_lane_array
//  Description : Directed self-checking bench for coin_lane_array.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_coin_lane_array;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] x = 16'd0, y = 16'd0;
  logic        v_sync = 1'b0, pause = 1'b0;
  logic        spawn_valid = 1'b0;
  logic [1:0]  spawn_lane = 2'd1, player_lane = 2'd1;

  logic        spawn_ready, sprite_hit, collect, miss;
  logic [7:0]  red, green, blue;
  logic [2:0]  in_pos;
  logic [1:0]  collect_lane;
  logic [15:0] score;

  logic        s_ready, s_hit, s_collect, s_miss;
  logic [7:0]  s_red, s_green, s_blue;
  logic [2:0]  s_in_pos;
  logic [1:0]  s_collect_lane;
  logic [1:0]  s_score;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  coin_lane_array dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_x(x), .i_y(y), .i_v_sync(v_sync),
    .i_pause(pause), .i_spawn_valid(spawn_valid), .i_spawn_lane(spawn_lane),
    .o_spawn_ready(spawn_ready), .i_player_lane(player_lane),
    .o_red(red), .o_green(green), .o_blue(blue), .o_sprite_hit(sprite_hit),
    .o_in_position(in_pos), .o_collect(collect), .o_collect_lane(collect_lane),
    .o_miss(miss), .o_score(score)
  );

  // Narrow score and short fall so saturation is reachable in a few frames.
  coin_lane_array #(.Y_HIT(4), .FLASH_FRAMES(2), .SCORE_W(2)) u_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_x(x), .i_y(y), .i_v_sync(v_sync),
    .i_pause(pause), .i_spawn_valid(spawn_valid), .i_spawn_lane(spawn_lane),
    .o_spawn_ready(s_ready), .i_player_lane(player_lane),
    .o_red(s_red), .o_green(s_green), .o_blue(s_blue), .o_sprite_hit(s_hit),
    .o_in_position(s_in_pos), .o_collect(s_collect), .o_collect_lane(s_collect_lane),
    .o_miss(s_miss), .o_score(s_score)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One frame: v_sync high for one cycle; returns right after the tick edge.
  task automatic do_tick();
    @(negedge clk) v_sync = 1'b1;
    @(negedge clk) v_sync = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  // Present a pixel; registered outputs are valid on return.
  task automatic probe(input int px, input int py);
    @(negedge clk);
    x = 16'(px);
    y = 16'(py);
    @(negedge clk);
  endtask

  task automatic spawn(input int lane);
    @(negedge clk);
    spawn_valid = 1'b1;
    spawn_lane  = 2'(lane);
    @(negedge clk);
    spawn_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst_rgb", 32'({red, green, blue}), 32'h0);
    check("rst_hit", 32'(sprite_hit), 0);
    check("rst_collect", 32'(collect), 0);
    check("rst_miss", 32'(miss), 0);
    check("rst_inpos", 32'(in_pos), 0);
    check("rst_score", 32'(score), 0);
    check("rst_ready", 32'(spawn_ready), 1);
    spawn_lane = 2'd3;
    #1;
    check("ready_badlane", 32'(spawn_ready), 0);
    @(negedge clk) rst_n = 1'b1;

    // Spawn lane 1: ready then drop
    @(negedge clk);
    spawn_valid = 1'b1;
    spawn_lane  = 2'd1;
    #1;
    check("spawn_ready_hi", 32'(spawn_ready), 1);
    @(negedge clk);
    #1;
    check("spawn_ready_lo", 32'(spawn_ready), 0);
    spawn_valid = 1'b0;

    // Pixel box of lane 1 at y=0: x in [304,336), y in [0,32)
    probe(310, 10);
    check("px_in_rgb", 32'({red, green, blue}), 32'hFFD700);
    check("px_in_hit", 32'(sprite_hit), 1);
    probe(336, 10);
    check("px_right_rgb", 32'({red, green, blue}), 32'h0);
    check("px_right_hit", 32'(sprite_hit), 0);
    probe(303, 10);
    check("px_left_hit", 32'(sprite_hit), 0);
    probe(335, 31);
    check("px_corner_hit", 32'(sprite_hit), 1);
    probe(335, 32);
    check("px_below_hit", 32'(sprite_hit), 0);

    // Fall to y=400
    ticks(99);
    check("inpos_t99", 32'(in_pos), 0);
    do_tick();
    check("inpos_t100", 32'(in_pos), 32'h2);
    probe(310, 399);
    check("px_y399", 32'(sprite_hit), 0);
    probe(310, 400);
    check("px_y400", 32'(sprite_hit), 1);

    // Pause freezes motion and collection
    pause = 1'b1;
    ticks(5);
    check("pause_inpos", 32'(in_pos), 32'h2);
    check("pause_collect", 32'(collect), 0);
    probe(310, 431);
    check("pause_y_bot", 32'(sprite_hit), 1);
    probe(310, 432);
    check("pause_y_past", 32'(sprite_hit), 0);

    // Spawn on a busy lane is refused
    @(negedge clk);
    spawn_valid = 1'b1;
    spawn_lane  = 2'd1;
    #1;
    check("busy_ready", 32'(spawn_ready), 0);
    @(negedge clk) spawn_valid = 1'b0;
    probe(310, 400);
    check("busy_nochange", 32'(sprite_hit), 1);

    // Releasing pause with v_sync held high must not tick
    @(negedge clk) v_sync = 1'b1;
    @(negedge clk);
    @(negedge clk) pause = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("no_false_tick", 32'(collect), 0);
    check("no_false_inpos", 32'(in_pos), 32'h2);
    v_sync = 1'b0;
    @(negedge clk);

    // Tick 101: collect
    do_tick();
    check("collect_pulse", 32'(collect), 1);
    check("collect_lane", 32'(collect_lane), 1);
    check("collect_score", 32'(score), 1);
    check("collect_inpos", 32'(in_pos), 0);
    @(negedge clk);
    check("collect_one_cyc", 32'(collect), 0);

    // Flash: cnt 7 visible white, cnt 5 hidden, idle after 8 ticks
    probe(310, 400);
    check("flash_white", 32'({red, green, blue}), 32'hFFFFFF);
    ticks(2);
    probe(310, 400);
    check("flash_hidden", 32'(sprite_hit), 0);
    check("flash_hidden_rgb", 32'({red, green, blue}), 32'h0);
    spawn_lane = 2'd1;
    ticks(5);
    check("flash_ready7", 32'(spawn_ready), 0);
    do_tick();
    check("flash_ready8", 32'(spawn_ready), 1);

    // Miss in lane 2
    player_lane = 2'd0;
    spawn(2);
    ticks(119);
    check("miss_t119", 32'(miss), 0);
    check("inpos_t119", 32'(in_pos), 32'h4);
    do_tick();
    check("miss_pulse", 32'(miss), 1);
    check("miss_inpos", 32'(in_pos), 0);
    check("miss_score", 32'(score), 1);
    @(negedge clk);
    check("miss_one_cyc", 32'(miss), 0);
    spawn_lane = 2'd2;
    #1;
    check("miss_ready", 32'(spawn_ready), 1);

    // Async reset mid-fall (lane 0 box x in [144,176))
    spawn(0);
    ticks(2);
    probe(150, 10);
    check("pre_rst_hit", 32'(sprite_hit), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_hit", 32'(sprite_hit), 0);
    check("arst_rgb", 32'({red, green, blue}), 32'h0);
    check("arst_score", 32'(score), 0);
    check("arst_inpos", 32'(in_pos), 0);
    @(negedge clk) rst_n = 1'b1;

    // Saturation on the 2-bit score instance
    player_lane = 2'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      spawn_valid = 1'b1;
      spawn_lane  = 2'd0;
      #1;
      check("sat_ready", 32'(s_ready), 1);
      @(negedge clk) spawn_valid = 1'b0;
      ticks(2);
      check("sat_collect", 32'(s_collect), 1);
      check("sat_score", 32'(s_score), (i < 3) ? i + 1 : 3);
      ticks(2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
